// File: rtl/multisim_push_serializer_if.sv
// Handshake bundle between an upstream message source, the serializer and a
// downstream beat-wide push client.
interface multisim_push_serializer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MSG_WIDTH  = 256
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [MSG_WIDTH-1:0]  in_data;
    logic                  out_vld;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    // serializer side
    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, out_last
    );

    // environment side: message source plus push client
    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, out_last
    );
endinterface

// File: rtl/multisim_push_serializer.sv
// Splits a MSG_WIDTH message into MSG_WIDTH/DATA_WIDTH beats, LSB beat first,
// with zero-bubble acceptance of the next message on the final beat.
module multisim_push_serializer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MSG_WIDTH  = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    multisim_push_serializer_if.slave        bus,
    output logic [31:0]                      msg_count
);
    localparam int unsigned BEATS = MSG_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((MSG_WIDTH < DATA_WIDTH) || ((MSG_WIDTH % DATA_WIDTH) != 0)) begin : g_bad_widths
        $error("MSG_WIDTH must be an integer multiple of DATA_WIDTH and >= DATA_WIDTH");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                             state;
    logic [BEATS-1:0][DATA_WIDTH-1:0]   msg_buf;
    logic [IDX_W-1:0]                   beat_idx;
    logic [IDX_W-1:0]                   nxt_idx;
    logic                               started;
    logic                               in_hs;
    logic                               out_hs;

    // started keeps in_rdy low until the first edge after reset release
    assign bus.in_rdy = started && ((state == IDLE) || (bus.out_rdy && bus.out_last));
    assign in_hs      = bus.in_vld && bus.in_rdy;
    assign out_hs     = bus.out_vld && bus.out_rdy;
    assign nxt_idx    = beat_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            msg_buf      <= '0;
            beat_idx     <= '0;
            started      <= 1'b0;
            bus.out_vld  <= 1'b0;
            bus.out_data <= '0;
            bus.out_last <= 1'b0;
            msg_count    <= '0;
        end else begin
            started <= 1'b1;
            // a new accept also covers the back-to-back case on the last beat
            if (in_hs) begin
                state        <= SEND;
                msg_buf      <= bus.in_data;
                beat_idx     <= '0;
                bus.out_vld  <= 1'b1;
                bus.out_data <= bus.in_data[DATA_WIDTH-1:0];
                bus.out_last <= (BEATS == 1);
            end else if (out_hs) begin
                if (bus.out_last) begin
                    state        <= IDLE;
                    bus.out_vld  <= 1'b0;
                    bus.out_last <= 1'b0;
                end else begin
                    beat_idx     <= nxt_idx;
                    bus.out_data <= msg_buf[nxt_idx];
                    bus.out_last <= (nxt_idx == IDX_W'(BEATS - 1));
                end
            end
            if (out_hs && bus.out_last) begin
                msg_count <= msg_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_multisim_push_serializer.sv
// Directed bench: 4-beat instance for the main scenarios and a 1-beat
// instance for the single-beat case; one shared clock and reset.
module tb_multisim_push_serializer;
    logic        clk;
    logic        rst;
    logic [31:0] cnt0;
    logic [31:0] cnt1;
    int          checks;
    int          failures;

    multisim_push_serializer_if #(.DATA_WIDTH(64), .MSG_WIDTH(256)) b0 ();
    multisim_push_serializer_if #(.DATA_WIDTH(64), .MSG_WIDTH(64))  b1 ();

    multisim_push_serializer #(.DATA_WIDTH(64), .MSG_WIDTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (b0.slave),
        .msg_count (cnt0)
    );

    multisim_push_serializer #(.DATA_WIDTH(64), .MSG_WIDTH(64)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b1.slave),
        .msg_count (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [63:0] mkw(input int m, input int k);
        return {8{4'(m + 5), 4'(k)}};
    endfunction

    function automatic logic [255:0] pkm(input int m);
        return {mkw(m, 3), mkw(m, 2), mkw(m, 1), mkw(m, 0)};
    endfunction

    task automatic beat(input string tag, input logic [63:0] d, input logic last);
        chk({tag, ".vld"},  64'(b0.out_vld), 64'd1);
        chk({tag, ".data"}, b0.out_data, d);
        chk({tag, ".last"}, 64'(b0.out_last), 64'(last));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
    endtask

    // Offer one message at the current low phase and check its four beats.
    task automatic run_msg(input string tag, input logic [255:0] msg);
        logic [3:0][63:0] wv;
        wv = msg;
        b0.in_data = msg;
        b0.in_vld  = 1'b1;
        b0.out_rdy = 1'b1;
        #1;
        chk({tag, ".accept_rdy"}, 64'(b0.in_rdy), 64'd1);
        chk({tag, ".pre_vld"},    64'(b0.out_vld), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            b0.in_vld = 1'b0;
            #1;
            beat(tag, wv[2'(k)], (k == 3));
            chk({tag, ".in_rdy"}, 64'(b0.in_rdy), 64'(k == 3));
        end
        step();
        #1;
        chk({tag, ".done_vld"}, 64'(b0.out_vld), 64'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        b0.in_vld  = 1'b0;
        b0.in_data = '0;
        b0.out_rdy = 1'b0;
        b1.in_vld  = 1'b0;
        b1.in_data = '0;
        b1.out_rdy = 1'b0;

        // Asynchronous reset before any clock edge
        #1;
        rst = 1'b1;
        #1;
        chk("rst.out_vld",   64'(b0.out_vld), 64'd0);
        chk("rst.out_last",  64'(b0.out_last), 64'd0);
        chk("rst.out_data",  b0.out_data, 64'd0);
        chk("rst.msg_count", 64'(cnt0), 64'd0);
        chk("rst.in_rdy",    64'(b0.in_rdy), 64'd0);
        chk("rst.cnt1",      64'(cnt1), 64'd0);
        step();
        step();
        chk("rst.in_rdy_clocked", 64'(b0.in_rdy), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel.in_rdy_pre_edge", 64'(b0.in_rdy), 64'd0);
        step();
        chk("rel.in_rdy", 64'(b0.in_rdy), 64'd1);

        // Basic four-beat message
        run_msg("basic", {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("basic.msg_count", 64'(cnt0), 64'd1);

        // Three back-to-back messages, no bubbles
        do_reset();
        b0.in_data = pkm(0);
        b0.in_vld  = 1'b1;
        b0.out_rdy = 1'b1;
        #1;
        chk("b2b.idle_rdy", 64'(b0.in_rdy), 64'd1);
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 4; k++) begin
                step();
                if (k == 0) begin
                    b0.in_vld = (m < 2);
                    if (m < 2) b0.in_data = pkm(m + 1);
                end
                #1;
                beat("b2b", mkw(m, k), (k == 3));
                chk("b2b.in_rdy", 64'(b0.in_rdy), 64'(k == 3));
            end
        end
        step();
        #1;
        chk("b2b.end_vld",   64'(b0.out_vld), 64'd0);
        chk("b2b.msg_count", 64'(cnt0), 64'd3);

        // Stall on beat 1 for five cycles
        b0.in_data = pkm(4);
        b0.in_vld  = 1'b1;
        #1;
        chk("stall.accept_rdy", 64'(b0.in_rdy), 64'd1);
        step();
        b0.in_vld = 1'b0;
        #1;
        beat("stall.b0", mkw(4, 0), 1'b0);
        step();
        #1;
        beat("stall.b1", mkw(4, 1), 1'b0);
        b0.out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            beat("stall.hold", mkw(4, 1), 1'b0);
            chk("stall.in_rdy", 64'(b0.in_rdy), 64'd0);
        end
        b0.out_rdy = 1'b1;
        step();
        #1;
        beat("stall.b2", mkw(4, 2), 1'b0);
        step();
        #1;
        beat("stall.b3", mkw(4, 3), 1'b1);
        step();
        #1;
        chk("stall.end_vld",   64'(b0.out_vld), 64'd0);
        chk("stall.msg_count", 64'(cnt0), 64'd4);

        // Reset after the beat-1 handshake
        b0.in_data = pkm(5);
        b0.in_vld  = 1'b1;
        step();
        b0.in_vld = 1'b0;
        step();
        step();
        #1;
        beat("rmid.b2_shown", mkw(5, 2), 1'b0);
        rst = 1'b1;
        #1;
        chk("rmid.out_vld",   64'(b0.out_vld), 64'd0);
        chk("rmid.out_last",  64'(b0.out_last), 64'd0);
        chk("rmid.out_data",  b0.out_data, 64'd0);
        chk("rmid.msg_count", 64'(cnt0), 64'd0);
        chk("rmid.in_rdy",    64'(b0.in_rdy), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            #1;
            chk("rmid.no_beat", 64'(b0.out_vld), 64'd0);
        end
        chk("rmid.cnt_after", 64'(cnt0), 64'd0);

        // Counter wrap from all-ones
        force dut.msg_count = 32'hFFFF_FFFF;
        #1;
        release dut.msg_count;
        #1;
        chk("wrap.preload", 64'(cnt0), 64'h0000_0000_FFFF_FFFF);
        run_msg("wrap", pkm(6));
        chk("wrap.msg_count", 64'(cnt0), 64'd0);

        // Single-beat instance, two back-to-back messages
        do_reset();
        b1.in_data = 64'hDEAD_BEEF_0123_4567;
        b1.in_vld  = 1'b1;
        b1.out_rdy = 1'b1;
        #1;
        chk("one.accept_rdy", 64'(b1.in_rdy), 64'd1);
        step();
        b1.in_data = 64'hCAFE_F00D_89AB_CDEF;
        #1;
        chk("one.b0_vld",  64'(b1.out_vld), 64'd1);
        chk("one.b0_data", b1.out_data, 64'hDEAD_BEEF_0123_4567);
        chk("one.b0_last", 64'(b1.out_last), 64'd1);
        chk("one.b0_rdy",  64'(b1.in_rdy), 64'd1);
        step();
        b1.in_vld = 1'b0;
        #1;
        chk("one.b1_vld",  64'(b1.out_vld), 64'd1);
        chk("one.b1_data", b1.out_data, 64'hCAFE_F00D_89AB_CDEF);
        chk("one.b1_last", 64'(b1.out_last), 64'd1);
        step();
        #1;
        chk("one.end_vld",   64'(b1.out_vld), 64'd0);
        chk("one.msg_count", 64'(cnt1), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multisim_push_serializer.md
MULTISIM_PUSH_SERIALIZER -- requirements
Module: multisim_push_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning beat width; it matches the downstream push client's DATA_WIDTH.
REQ-002 The block SHALL have parameter MSG_WIDTH, default 256, meaning input message width; it must be an integer multiple of DATA_WIDTH and >= DATA_WIDTH, else elaboration error.
REQ-003 The block SHALL derive BEATS = MSG_WIDTH/DATA_WIDTH and size the beat index as max(1, $clog2(BEATS)) bits.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 The block SHALL have port in_vld, input, 1, meaning an upstream message is offered.
REQ-007 The block SHALL have port in_rdy, output, 1, meaning the block accepts a message this cycle.
REQ-008 The block SHALL have port in_data, input, MSG_WIDTH, meaning the message payload.
REQ-009 The block SHALL have port out_vld, output, 1, which connects to the push client's data_vld.
REQ-010 The block SHALL have port out_rdy, input, 1, which connects from the push client's data_rdy.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH, which connects to the push client's data.
REQ-012 The block SHALL have port out_last, output, 1, asserted on the final beat of a message.
REQ-013 The block SHALL have port msg_count, output, 32, counting completed messages.

Function
REQ-014 Handshakes SHALL occur on a posedge where vld and rdy are both 1; there is no combinational path from out_rdy to out_vld.
REQ-015 The FSM SHALL have states IDLE and SEND, with the IDLE state giving out_vld=0 and the SEND state giving out_vld=1.
REQ-016 In IDLE, in_rdy SHALL be 1; on an in handshake, in_data is captured into msg_buf, beat_idx is set to 0, and the state moves to SEND.
REQ-017 In SEND, out_data SHALL equal msg_buf[beat_idx*DATA_WIDTH +: DATA_WIDTH], with beat 0 as the LSBs.
REQ-018 out_last SHALL be 1 iff state is SEND and beat_idx == BEATS-1.
REQ-019 On an out handshake with out_last=0, beat_idx SHALL increment by 1.
REQ-020 In SEND, in_rdy SHALL equal out_rdy && out_last, giving zero-bubble back-to-back messages.
REQ-021 On an out handshake with out_last=1 without an in handshake, the state SHALL move to IDLE.
REQ-022 On an out handshake with out_last=1 plus an in handshake on the same edge, the block SHALL stay in SEND, load the new message, and set beat_idx to 0.
REQ-023 When out_vld=1 and out_rdy=0, out_data, out_last and beat_idx SHALL hold unchanged (stall).
REQ-024 Latency from in handshake to first out_vld SHALL be 1 cycle; a message occupies exactly BEATS out handshakes.
REQ-025 When BEATS==1, out_last SHALL be constantly 1 in SEND and every out handshake completes a message.
REQ-026 msg_count SHALL increment by 1 on every out handshake with out_last=1 and wrap from 0xFFFFFFFF to 0.
REQ-027 in_data SHALL be ignored when in_rdy=0; msg_buf changes only on an in handshake.

Reset
REQ-028 Assertion of rst SHALL immediately, without a clock, force the state to IDLE, out_vld=0, out_last=0, beat_idx=0, msg_count=0 and out_data=0.
REQ-029 In reset, in_rdy SHALL be 0; after rst deasserts, in_rdy is 1 from the first posedge onward.
REQ-030 A reset asserted mid-message SHALL discard the partial message; no remaining beats are emitted after release.

Verification
REQ-031 The bench SHALL cover the basic case: in_data=256'h4444..._3333..._2222..._1111... (64-bit words), out_rdy=1 -> beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 consecutive cycles starting 1 cycle after accept; out_last only on the 4th; msg_count=1.
REQ-032 The bench SHALL cover back-to-back messages: in_vld held high with 3 messages, out_rdy=1 -> 12 consecutive beats with no bubble; in_rdy pulses only on out_last cycles; msg_count=3.
REQ-033 The bench SHALL cover stall: out_rdy=0 for 5 cycles during beat 1 -> out_data stays beat 1 and out_vld stays 1; the sequence resumes at beat 2 with no duplicate or lost beat.
REQ-034 The bench SHALL cover reset mid-message: rst asserted after beat 1 handshake -> out_vld=0 with no clock; after release no beats are emitted until a new accept, and msg_count=0.
REQ-035 The bench SHALL cover wrap: msg_count forced or preloaded to 0xFFFFFFFF, then one message completes -> msg_count=0.
REQ-036 The bench SHALL cover BEATS==1 (MSG_WIDTH=64): 2 back-to-back messages with out_rdy=1 -> 2 beats on consecutive cycles, out_last=1 on both, msg_count=2.
